// File: rtl/pipe_wb_stage_if.sv
// MEM->WB bundle: M-stage outputs and pipeline control going in,
// register-file write port, HI/LO and their forwarding values coming out.
interface pipe_wb_stage_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             bubble;
    logic [WIDTH-1:0] Malu;
    logic [WIDTH-1:0] Ma;
    logic [WIDTH-1:0] Mdm;
    logic [WIDTH-1:0] Mpc4;
    logic [WIDTH-1:0] Mcp0;
    logic [WIDTH-1:0] Mcounter;
    logic [WIDTH-1:0] Mmuler_hi;
    logic [WIDTH-1:0] Mmuler_lo;
    logic [WIDTH-1:0] Mq;
    logic [WIDTH-1:0] Mr;
    logic [2:0]       Mrfsource;
    logic [1:0]       Mcuttersource;
    logic             Msign;
    logic [1:0]       Mhisource;
    logic [1:0]       Mlosource;
    logic [4:0]       Mrn;
    logic             Mw_rf;
    logic             Mw_hi;
    logic             Mw_lo;
    logic [WIDTH-1:0] wdata;
    logic [4:0]       wrn;
    logic             wrf;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] fwd_hi;
    logic [WIDTH-1:0] fwd_lo;

    modport master (
        output stall, bubble, Malu, Ma, Mdm, Mpc4, Mcp0, Mcounter,
               Mmuler_hi, Mmuler_lo, Mq, Mr, Mrfsource, Mcuttersource, Msign,
               Mhisource, Mlosource, Mrn, Mw_rf, Mw_hi, Mw_lo,
        input  wdata, wrn, wrf, hi, lo, fwd_hi, fwd_lo
    );

    modport slave (
        input  stall, bubble, Malu, Ma, Mdm, Mpc4, Mcp0, Mcounter,
               Mmuler_hi, Mmuler_lo, Mq, Mr, Mrfsource, Mcuttersource, Msign,
               Mhisource, Mlosource, Mrn, Mw_rf, Mw_hi, Mw_lo,
        output wdata, wrn, wrf, hi, lo, fwd_hi, fwd_lo
    );
endinterface

// File: rtl/pipe_wb_stage.sv
// MEM/WB pipeline register, load cutter, write-data mux and architectural HI/LO.
// Only WIDTH = 32 is meaningful (byte/halfword lane selection assumes a 32-bit word).
module pipe_wb_stage #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_wb_stage_if.slave    bus
);
    typedef struct packed {
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] dm;
        logic [WIDTH-1:0] pc4;
        logic [WIDTH-1:0] cp0;
        logic [WIDTH-1:0] counter;
        logic [WIDTH-1:0] muler_hi;
        logic [WIDTH-1:0] muler_lo;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [2:0]       rfsource;
        logic [1:0]       cuttersource;
        logic             sign;
        logic [1:0]       hisource;
        logic [1:0]       losource;
        logic [4:0]       rn;
        logic             w_rf;
        logic             w_hi;
        logic             w_lo;
    } wb_reg_t;

    wb_reg_t          w, nxt;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH-1:0] cut;
    logic [WIDTH-1:0] wd;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    // A bubble still latches the payload; only the write enables are killed.
    always_comb begin
        nxt = '{
            alu:          bus.Malu,
            a:            bus.Ma,
            dm:           bus.Mdm,
            pc4:          bus.Mpc4,
            cp0:          bus.Mcp0,
            counter:      bus.Mcounter,
            muler_hi:     bus.Mmuler_hi,
            muler_lo:     bus.Mmuler_lo,
            q:            bus.Mq,
            r:            bus.Mr,
            rfsource:     bus.Mrfsource,
            cuttersource: bus.Mcuttersource,
            sign:         bus.Msign,
            hisource:     bus.Mhisource,
            losource:     bus.Mlosource,
            rn:           bus.Mrn,
            w_rf:         bus.Mw_rf,
            w_hi:         bus.Mw_hi,
            w_lo:         bus.Mw_lo
        };
        if (bus.bubble) begin
            nxt.w_rf = 1'b0;
            nxt.w_hi = 1'b0;
            nxt.w_lo = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            w <= '0;
        else if (bus.bubble || !bus.stall)
            w <= nxt;
    end

    assign byte_sel = w.dm[8*w.alu[1:0] +: 8];
    assign half_sel = w.alu[1] ? w.dm[31:16] : w.dm[15:0];

    always_comb begin
        cut = w.dm;
        unique case (w.cuttersource)
            2'b01:   cut = {{(WIDTH-8){w.sign & byte_sel[7]}}, byte_sel};
            2'b10:   cut = {{(WIDTH-16){w.sign & half_sel[15]}}, half_sel};
            default: cut = w.dm;
        endcase
    end

    // mfhi/mflo read the committed registers; same-cycle hazards go through fwd_*.
    always_comb begin
        wd = w.alu;
        unique case (w.rfsource)
            3'd1:    wd = cut;
            3'd2:    wd = w.pc4;
            3'd3:    wd = hi_q;
            3'd4:    wd = lo_q;
            3'd5:    wd = w.cp0;
            3'd6:    wd = w.counter;
            default: wd = w.alu;
        endcase
    end

    always_comb begin
        hi_nxt = hi_q;
        unique case (w.hisource)
            2'd0:    hi_nxt = w.a;
            2'd1:    hi_nxt = w.muler_hi;
            2'd2:    hi_nxt = w.r;
            default: hi_nxt = hi_q;
        endcase
    end

    always_comb begin
        lo_nxt = lo_q;
        unique case (w.losource)
            2'd0:    lo_nxt = w.a;
            2'd1:    lo_nxt = w.muler_lo;
            2'd2:    lo_nxt = w.q;
            default: lo_nxt = lo_q;
        endcase
    end

    // A stalled instruction rewrites the same value, so no stall gating here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (w.w_hi) hi_q <= hi_nxt;
            if (w.w_lo) lo_q <= lo_nxt;
        end
    end

    assign bus.wdata  = wd;
    assign bus.wrn    = w.rn;
    assign bus.wrf    = w.w_rf & (w.rn != 5'd0);
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.fwd_hi = hi_nxt;
    assign bus.fwd_lo = lo_nxt;
endmodule

// File: doc/pipe_wb_stage.md
Name: pipe_wb_stage

Overview:
- MEM/WB pipeline register plus write-back stage of the dynamic pipeline CPU.
- Captures everything the MEM stage presents on its M-prefixed outputs at each clock edge.
- Sign/zero-extends byte and halfword loads, and selects the register-file write data.
- Owns the architectural HI/LO registers. Drives the register-file write port and the forwarding paths back to ID/EX.

Parameters:
- WIDTH, 32, datapath width. Fixed at 32 for the MIPS subset; other values are not supported.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold WB register contents
- bubble  in  1  replace the incoming instruction with a no-op
- Malu  in  32  ALU result / memory address
- Ma  in  32  rs value (mthi/mtlo source)
- Mdm  in  32  raw data-memory read word
- Mpc4  in  32  PC+4 (link address)
- Mcp0  in  32  CP0 read value
- Mcounter  in  32  clz/clo count result
- Mmuler_hi, Mmuler_lo  in  32 each  multiplier result halves
- Mq, Mr  in  32 each  divider quotient / remainder
- Mrfsource  in  3  write-data select
- Mcuttersource  in  2  load width select
- Msign  in  1  1 = sign-extend load
- Mhisource, Mlosource  in  2 each  HI/LO next-value select
- Mrn  in  5  destination register
- Mw_rf, Mw_hi, Mw_lo  in  1 each  write enables
- wdata  out  32  register-file write data
- wrn  out  5  register-file write address
- wrf  out  1  register-file write enable
- hi, lo  out  32 each  architectural HI/LO
- fwd_hi, fwd_lo  out  32 each  HI/LO values being written this cycle, for forwarding

Behaviour:
- Reset and clock: clk is the single clock. rst is asynchronous and active-high.
- Reset values: all WB pipeline registers = 0; hi = lo = 0; wrf = 0; wrn = 0; wdata = 0.
- Capture: at rising clk with rst = 0:
  - If bubble = 1, latch W-copies of all inputs but force W_w_rf = W_w_hi = W_w_lo = 0.
  - Else if stall = 1, hold every W register.
  - Else latch all inputs.
  - Priority: rst > bubble > stall.
- Latency: one cycle from MEM inputs to the wdata/wrn/wrf outputs, which are combinational from the W registers. HI/LO update on the edge ending the WB cycle, i.e. two edges after MEM.
- Load cutter (combinational on W values), off = W_alu[1:0]:
  - Mcuttersource 00: full word.
  - Mcuttersource 01: byte Wdm[8*off+7 : 8*off].
  - Mcuttersource 10: halfword Wdm[16*off[1]+15 : 16*off[1]].
  - Mcuttersource 11: treated as word.
  - Extension: sign-extend when W_sign = 1, otherwise zero-extend.
- rfsource select:
  - 0 alu
  - 1 cut load data
  - 2 pc4
  - 3 hi register
  - 4 lo register
  - 5 cp0
  - 6 counter
  - 7 alu
- Register-file write: wrn = W_rn. wrf = W_w_rf & (W_rn != 0), so writes to $0 are suppressed.
- HI next value (fwd_hi), by hisource:
  - 0 Ma copy
  - 1 muler_hi
  - 2 r
  - 3 current hi
- LO next value (fwd_lo), by losource:
  - 0 Ma copy
  - 1 muler_lo
  - 2 q
  - 3 current lo
- HI/LO registers: at rising clk, if W_w_hi then hi <= fwd_hi; if W_w_lo then lo <= fwd_lo. Independent enables, so both may be written in the same cycle (mult/div).
- HI/LO while stalled: writes still occur while stall = 1, because the held instruction rewrites the same value. The result is idempotent except for source 3, which is also idempotent.
- Read-after-write on HI/LO: mfhi in WB while an older mthi has already committed reads the updated hi. Same-cycle hazards are the forwarding unit's job via fwd_hi/fwd_lo.
- rst mid-operation: state clears immediately, with no write on that edge.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with W_w_rf = 1 -> wrf drops to 0 at once; hi = lo = 0.
- Byte load: Mdm = 0x80FF7F01, Malu = 0x...03, cut = 01, sign = 1, rfsource = 1, rn = 8, w_rf = 1 -> next cycle wdata = 0xFFFFFF80, wrn = 8, wrf = 1. Same stimulus with sign = 0 -> wdata = 0x00000080.
- Halfword load: Malu[1:0] = 2, Mdm = 0x8001_1234, cut = 10, sign = 1 -> wdata = 0xFFFF8001.
- mult then mfhi/mflo:
  - mult: muler_hi = 0x1, muler_lo = 0xFFFF0000, hisource = losource = 1, w_hi = w_lo = 1.
  - One cycle later, mfhi (rfsource = 3) -> wdata = 0x00000001.
  - Next, mflo (rfsource = 4) -> wdata = 0xFFFF0000.
- $0 and control: rn = 0, w_rf = 1 -> wrf = 0. Then assert bubble with w_rf = 1, rn = 5 -> wrf = 0 the next cycle. Then assert stall for 3 cycles -> wdata/wrn/wrf stay frozen.
- div then mtlo:
  - div: q = 7, r = 3, hisource = 2, losource = 2 -> hi = 3, lo = 7.
  - Then mtlo: Ma = 0xABCD, losource = 0, w_lo = 1 -> lo = 0xABCD, hi stays 3.
